// File: rtl/do_popcount_accum_if.sv
// Handshake bundle between the do-bus sampler and the popcount accumulator.
// Carries both the sample port and the window-result port.
interface do_popcount_accum_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SUM_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [SUM_W-1:0] out_toggles;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_toggles
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_toggles
  );
endinterface

// File: rtl/do_popcount_accum.sv
// Accumulates popcount and bit-toggle totals over a fixed window of accepted do-bus
// samples and presents each window's totals on a valid/ready result port.
module do_popcount_accum #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned SUM_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  do_popcount_accum_if.slave   bus
);

  localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned PC_W  = $clog2(WIDTH + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   sum_acc;
  logic [SUM_W-1:0]   tog_acc;
  logic [WIDTH-1:0]   prev;
  logic               accept;
  logic               last;
  logic [SUM_W-1:0]   pc_sum;
  logic [SUM_W-1:0]   pc_tog;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  // Same-cycle popcounts feeding the accumulator update
  always_comb begin
    accept = bus.in_valid && (state == ACCUM);
    last   = accept && (cnt == CNT_W'(WINDOW - 1));
    pc_sum = SUM_W'(popcount(bus.in_data));
    pc_tog = SUM_W'(popcount(bus.in_data ^ prev));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (last)          state_nx = HOLD;
      HOLD:    if (bus.out_ready) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  // Handshake flags decode straight from the state flop, so they never overlap
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ACCUM:   bus.in_ready  = 1'b1;
      HOLD:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // prev survives window boundaries; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt             <= '0;
      sum_acc         <= '0;
      tog_acc         <= '0;
      prev            <= '0;
      bus.out_sum     <= '0;
      bus.out_toggles <= '0;
    end else if (accept) begin
      prev <= bus.in_data;
      if (last) begin
        cnt             <= '0;
        sum_acc         <= '0;
        tog_acc         <= '0;
        bus.out_sum     <= sum_acc + pc_sum;
        bus.out_toggles <= tog_acc + pc_tog;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        sum_acc <= sum_acc + pc_sum;
        tog_acc <= tog_acc + pc_tog;
      end
    end
  end

endmodule

// File: tb/tb_do_popcount_accum.sv
// Directed bench for do_popcount_accum: window totals, latency, back-pressure,
// gapped input and asynchronous reset recovery.
module tb_do_popcount_accum;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  do_popcount_accum_if #(.WIDTH(8), .SUM_W(8)) bus();

  do_popcount_accum #(.WIDTH(8), .WINDOW(16), .SUM_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int s, input int t);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_sum"},       32'(bus.out_sum),   32'(s));
    check({tag, "_toggles"},   32'(bus.out_toggles), 32'(t));
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_rel_in_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready",  32'(bus.in_ready),    32'd1);
    check("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check("rst_sum",       32'(bus.out_sum),     32'd0);
    check("rst_toggles",   32'(bus.out_toggles), 32'd0);

    // 16 x 0xFF: result visible one cycle after the last accept
    for (int i = 0; i < 16; i++) push(8'hFF);
    check_result("ff16", 128, 8);
    release_result("ff16");

    // Alternating 0xAA/0x55
    do_reset();
    for (int i = 0; i < 16; i++) push((i % 2 == 0) ? 8'hAA : 8'h55);
    check_result("alt", 64, 124);
    release_result("alt");

    // Window 1 ends with 0xFF, window 2 is all 0xFF: no toggles carried over
    do_reset();
    for (int i = 0; i < 15; i++) push(8'h00);
    push(8'hFF);
    check_result("w1", 8, 8);
    release_result("w1");
    for (int i = 0; i < 16; i++) push(8'hFF);
    check_result("w2", 128, 0);

    // Back-pressure with in_valid held high and data changing
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i * 37 + 3);
      @(negedge clk);
      check_result("hold", 128, 0);
    end
    bus.in_data = 8'hA5;
    release_result("hold");
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h00);
    check_result("post_hold", 0, 8);
    release_result("post_hold");

    // Gapped 0x0F samples
    do_reset();
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(8'h0F);
    end
    check_result("gap", 64, 4);
    release_result("gap");

    // Asynchronous reset mid-window, between clock edges
    for (int i = 0; i < 7; i++) push(8'hFF);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sum",       32'(bus.out_sum),     32'd0);
    check("arst_toggles",   32'(bus.out_toggles), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid),   32'd0);
    check("arst_in_ready",  32'(bus.in_ready),    32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h01);
    check_result("after_arst", 16, 1);
    release_result("after_arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
